// File: rtl/pattern_engine_if.sv
// pattern_engine_if: timing-generator inputs and pixel/event outputs of the pattern engine
interface pattern_engine_if #(parameter int COLOR_W = 4);
  logic [9:0]         position_x;
  logic [9:0]         position_x_NEXT;
  logic [8:0]         position_y;
  logic [8:0]         position_y_NEXT;
  logic               frame_start;
  logic [1:0]         mode_i;
  logic [COLOR_W-1:0] r;
  logic [COLOR_W-1:0] g;
  logic [COLOR_W-1:0] b;
  logic               corner_hit;
  modport master (
    output position_x, position_x_NEXT, position_y, position_y_NEXT, frame_start, mode_i,
    input  r, g, b, corner_hit
  );
  modport slave (
    input  position_x, position_x_NEXT, position_y, position_y_NEXT, frame_start, mode_i,
    output r, g, b, corner_hit
  );
endinterface

// File: rtl/pattern_engine.sv
// pattern_engine: registered checkerboard / carpet fractal / bouncing sprite pixel source
module pattern_engine #(
  parameter int COLOR_W    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int TILE_SHIFT = 2,
  parameter int FRAC_BITS  = 9,
  parameter int FRAC_Y_OFF = 16,
  parameter int SPRITE_SZ  = 32
) (
  input logic clk,
  input logic rst_n,
  pattern_engine_if.slave bus
);
  localparam int FRAC_W = 1 << FRAC_BITS;
  localparam int X0     = (H_ACTIVE - FRAC_W) / 2;
  localparam int MAX_X  = H_ACTIVE - SPRITE_SZ;
  localparam int MAX_Y  = V_ACTIVE - SPRITE_SZ;
  logic [1:0]           mode_q, mode_d;
  logic [2:0]           cc_q, cc_d;
  logic [9:0]           spr_x_q, spr_x_d;
  logic [8:0]           spr_y_q, spr_y_d;
  logic                 up_x_q, up_x_d, up_y_q, up_y_d;
  logic [COLOR_W-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
  logic                 corner_hit_q, corner_hit_d;
  logic [10:0]          x, x_off;
  logic [9:0]           y, y_off;
  logic [FRAC_BITS-1:0] sx, sy;
  logic                 active, chk_on, frac_on, spr_on, refl_x, refl_y;
  logic [2:0]           en, on_rgb;
  logic                 unused_pos;
  assign unused_pos = ^{bus.position_x, bus.position_y};
  // Widened copies keep every range compare and sum free of wrap-around
  always_comb begin
    x       = {1'b0, bus.position_x_NEXT};
    y       = {1'b0, bus.position_y_NEXT};
    active  = (x < 11'(H_ACTIVE)) && (y < 10'(V_ACTIVE));
    chk_on  = bus.position_x_NEXT[TILE_SHIFT] ^ bus.position_y_NEXT[TILE_SHIFT];
    x_off   = x - 11'(X0);
    y_off   = y + 10'(FRAC_Y_OFF);
    sx      = x_off[FRAC_BITS-1:0];
    sy      = y_off[FRAC_BITS-1:0];
    frac_on = (x >= 11'(X0)) && (x < 11'(X0 + FRAC_W));
    for (int i = FRAC_BITS - 1; i >= 1; i -= 2)
      frac_on = frac_on & ((sx[i] ^ sx[i-1]) | (sy[i] ^ sy[i-1]));
    spr_on  = (x >= {1'b0, spr_x_q}) && (x < {1'b0, spr_x_q} + 11'(SPRITE_SZ)) &&
              (y >= {1'b0, spr_y_q}) && (y < {1'b0, spr_y_q} + 10'(SPRITE_SZ));
    en      = {cc_q[1], cc_q[0], cc_q[2]};
    on_rgb  = mode_q == 2'd0 ? {3{chk_on}} & en :
              mode_q == 2'd1 ? {3{frac_on}} :
              mode_q == 2'd2 ? {3{spr_on}} & (cc_q == 3'd0 ? 3'b111 : en) : 3'b000;
    on_rgb  = on_rgb & {3{active}};
    r_d     = {COLOR_W{on_rgb[2]}};
    g_d     = {COLOR_W{on_rgb[1]}};
    b_d     = {COLOR_W{on_rgb[0]}};
  end
  // Frame state advances only on frame_start; the pixel of that edge still sees the old state
  always_comb begin
    refl_x       = up_x_q ? spr_x_q == 10'(MAX_X) : spr_x_q == 10'd0;
    refl_y       = up_y_q ? spr_y_q == 9'(MAX_Y) : spr_y_q == 9'd0;
    mode_d       = bus.frame_start ? bus.mode_i : mode_q;
    cc_d         = bus.frame_start ? cc_q + 3'd1 : cc_q;
    up_x_d       = bus.frame_start & refl_x ? ~up_x_q : up_x_q;
    up_y_d       = bus.frame_start & refl_y ? ~up_y_q : up_y_q;
    spr_x_d      = !bus.frame_start ? spr_x_q :
                   refl_x ? (up_x_q ? 10'(MAX_X - 1) : 10'd1) :
                   (up_x_q ? spr_x_q + 10'd1 : spr_x_q - 10'd1);
    spr_y_d      = !bus.frame_start ? spr_y_q :
                   refl_y ? (up_y_q ? 9'(MAX_Y - 1) : 9'd1) :
                   (up_y_q ? spr_y_q + 9'd1 : spr_y_q - 9'd1);
    corner_hit_d = bus.frame_start & refl_x & refl_y;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= '0;
      cc_q         <= '0;
      spr_x_q      <= '0;
      spr_y_q      <= '0;
      up_x_q       <= 1'b1;
      up_y_q       <= 1'b1;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      corner_hit_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      cc_q         <= cc_d;
      spr_x_q      <= spr_x_d;
      spr_y_q      <= spr_y_d;
      up_x_q       <= up_x_d;
      up_y_q       <= up_y_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
      corner_hit_q <= corner_hit_d;
    end
  end
  assign bus.r          = r_q;
  assign bus.g          = g_q;
  assign bus.b          = b_q;
  assign bus.corner_hit = corner_hit_q;
endmodule

// File: tb/tb_pattern_engine.sv
// tb_pattern_engine: randomized scoreboard bench for pattern_engine (default sprite and a 160 px sprite)
module tb_pattern_engine;
  typedef struct packed {logic [3:0] r; logic [3:0] g; logic [3:0] b; logic c;} px_t;
  typedef struct packed {px_t s; px_t l;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pattern_engine_if #(.COLOR_W(4)) bus ();
  pattern_engine_if #(.COLOR_W(4)) bus2 ();
  assign bus2.position_x      = bus.position_x;
  assign bus2.position_x_NEXT = bus.position_x_NEXT;
  assign bus2.position_y      = bus.position_y;
  assign bus2.position_y_NEXT = bus.position_y_NEXT;
  assign bus2.frame_start     = bus.frame_start;
  assign bus2.mode_i          = bus.mode_i;
  pattern_engine u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  pattern_engine #(.SPRITE_SZ(160)) u_big (.clk(clk), .rst_n(rst_n), .bus(bus2));
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int m_mode, m_cc;
  int spx[2], spy[2], sdx[2], sdy[2];
  int ssz[2] = '{32, 160};
  task automatic model_reset();
    m_mode = 0;
    m_cc = 0;
    for (int k = 0; k < 2; k++) begin
      spx[k] = 0; spy[k] = 0; sdx[k] = 1; sdy[k] = 1;
    end
  endtask
  function automatic px_t pixel(int k, int x, int y);
    px_t p;
    int on;
    int a, b;
    bit [2:0] rgb, en;
    p = '0;
    rgb = 3'b000;
    en = {bit'((m_cc / 2) % 2), bit'(m_cc % 2), bit'((m_cc / 4) % 2)};
    if (x >= 640 || y >= 480) return p;
    if (m_mode == 0) begin
      if (((x / 4) + (y / 4)) % 2 == 1) rgb = en;
    end else if (m_mode == 1) begin
      if (x >= 64 && x < 576) begin
        a = (x - 64) % 512;
        b = (y + 16) % 512;
        on = 1;
        for (int i = 8; i >= 1; i -= 2) begin
          if ((((a >> (i - 1)) % 4) % 3 == 0) && (((b >> (i - 1)) % 4) % 3 == 0)) on = 0;
        end
        if (on != 0) rgb = 3'b111;
      end
    end else if (m_mode == 2) begin
      if (x >= spx[k] && x < spx[k] + ssz[k] && y >= spy[k] && y < spy[k] + ssz[k])
        rgb = (m_cc == 0) ? 3'b111 : en;
    end
    p.r = rgb[2] ? 4'hF : 4'h0;
    p.g = rgb[1] ? 4'hF : 4'h0;
    p.b = rgb[0] ? 4'hF : 4'h0;
    return p;
  endfunction
  function automatic int bounce(int p, int d, int mx, output int np, output int nd);
    if (d > 0 && p == mx) begin np = mx - 1; nd = -1; return 1; end
    if (d < 0 && p == 0) begin np = 1; nd = 1; return 1; end
    np = p + d; nd = d;
    return 0;
  endfunction
  task automatic step(int x, int y, bit fs, int mode);
    exp_t e;
    int hx, hy, np, nd;
    @(negedge clk);
    bus.position_x      = bus.position_x_NEXT;
    bus.position_y      = bus.position_y_NEXT;
    bus.position_x_NEXT = 10'(x);
    bus.position_y_NEXT = 9'(y);
    bus.frame_start     = fs;
    bus.mode_i          = 2'(mode);
    e.s = pixel(0, x, y);
    e.l = pixel(1, x, y);
    if (fs) begin
      m_mode = mode;
      m_cc = (m_cc + 1) % 8;
      for (int k = 0; k < 2; k++) begin
        hx = bounce(spx[k], sdx[k], 640 - ssz[k], np, nd);
        spx[k] = np; sdx[k] = nd;
        hy = bounce(spy[k], sdy[k], 480 - ssz[k], np, nd);
        spy[k] = np; sdy[k] = nd;
        if (k == 0) e.s.c = (hx != 0 && hy != 0);
        else e.l.c = (hx != 0 && hy != 0);
      end
    end
    q.push_back(e);
  endtask
  task automatic cmp(string nm, px_t act, px_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got r=%h g=%h b=%h hit=%b, want r=%h g=%h b=%h hit=%b",
               nm, act.r, act.g, act.b, act.c, exp.r, exp.g, exp.b, exp.c);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        cmp("pix32", {bus.r, bus.g, bus.b, bus.corner_hit}, e.s);
        cmp("pix160", {bus2.r, bus2.g, bus2.b, bus2.corner_hit}, e.l);
      end
    end
  end
  task automatic rand_pixel();
    int k, x, y;
    if ($urandom_range(0, 1) == 1) begin
      k = int'($urandom_range(0, 1));
      x = spx[k] + int'($urandom_range(0, ssz[k] + 1)) - 1;
      y = spy[k] + int'($urandom_range(0, ssz[k] + 1)) - 1;
      x = x < 0 ? 0 : x;
      y = y < 0 ? 0 : (y > 511 ? 511 : y);
    end else begin
      x = int'($urandom_range(0, 700));
      y = int'($urandom_range(0, 511));
    end
    step(x, y, 1'b0, int'($urandom_range(0, 3)));
  endtask
  initial begin
    bus.position_x = '0;
    bus.position_x_NEXT = '0;
    bus.position_y = '0;
    bus.position_y_NEXT = '0;
    bus.frame_start = 1'b0;
    bus.mode_i = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    cmp("reset32", {bus.r, bus.g, bus.b, bus.corner_hit}, '0);
    cmp("reset160", {bus2.r, bus2.g, bus2.b, bus2.corner_hit}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    step(700, 500, 1'b1, 0);
    step(4, 0, 1'b0, 0);
    step(4, 4, 1'b0, 0);
    step(5, 0, 1'b0, 3);
    step(639, 3, 1'b0, 1);
    step(640, 3, 1'b0, 1);
    step(6, 479, 1'b0, 1);
    step(6, 480, 1'b0, 1);
    step(0, 490, 1'b1, 1);
    step(63, 0, 1'b0, 2);
    step(64, 0, 1'b0, 2);
    step(575, 0, 1'b0, 2);
    step(576, 0, 1'b0, 2);
    repeat (300) step(int'($urandom_range(0, 700)), int'($urandom_range(0, 511)), 1'b0, 1);
    step(0, 490, 1'b1, 2);
    step(spx[0], spy[0], 1'b0, 0);
    step(spx[0] + 31, spy[0] + 31, 1'b0, 0);
    step(spx[0] + 32, spy[0], 1'b0, 0);
    step(spx[0], spy[0] + 32, 1'b0, 0);
    for (int f = 0; f < 1000; f++) begin
      step(int'($urandom_range(640, 799)), 495, 1'b1, int'($urandom_range(0, 3)));
      repeat (15) rand_pixel();
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    cmp("async_rst32", {bus.r, bus.g, bus.b, bus.corner_hit}, '0);
    cmp("async_rst160", {bus2.r, bus2.g, bus2.b, bus2.corner_hit}, '0);
    q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 490, 1'b1, 2);
    step(1, 1, 1'b0, 2);
    step(0, 0, 1'b0, 2);
    step(33, 1, 1'b0, 2);
    repeat (50) rand_pixel();
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
